// File: rtl/pipe_stage_regs.sv
// Fetch PC, IF/ID and ID/EX pipeline registers with hazard stall/flush
// control and saturating stall/flush event counters.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   PCNextF           next fetch PC; PCF is the fetch PC register
//   InstrF, PCPlus4F  fetch-side values captured into IF/ID
//   StallF, StallD    hold PC / IF/ID on the current edge
//   FlushD, FlushE    squash IF/ID / ID/EX on the current edge
//   Rs1D..MemWriteD   decode-side fields captured into ID/EX
//   CntClr            clear both event counters
//   *D, *E outputs    IF/ID and ID/EX register contents
//   StallCnt/FlushCnt saturating counts of StallF / FlushD edges
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCNextF,
  input  logic [31:0]      InstrF,
  input  logic [31:0]      PCPlus4F,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic             ResultSrcD0,
  input  logic             MemWriteD,
  input  logic             CntClr,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             RegWriteE,
  output logic             ResultSrcE0,
  output logic             MemWriteE,
  output logic             ValidE,
  output logic [31:0]      PCE,
  output logic [31:0]      PCPlus4E,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      PCF <= PCNextF;
    end
  end

  // Flush takes priority over stall.
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  // Control bits are gated by ValidD so an invalid slot entering EX
  // can never write the register file or memory.
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteE   <= 1'b0;
      ResultSrcE0 <= 1'b0;
      MemWriteE   <= 1'b0;
      ValidE      <= 1'b0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
      RegWriteE   <= RegWriteD & ValidD;
      ResultSrcE0 <= ResultSrcD0 & ValidD;
      MemWriteE   <= MemWriteD & ValidD;
      ValidE      <= ValidD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || CntClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1)) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end
      if (FlushD && (FlushCnt != '1)) begin
        FlushCnt <= FlushCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Randomized and directed bench for pipe_stage_regs against a
// behavioural model of the pipeline slots and event counters.
module tb_pipe_stage_regs;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCNextF, InstrF, PCPlus4F;
  logic        StallF, StallD, FlushD, FlushE;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, ResultSrcD0, MemWriteD, CntClr;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, PCE, PCPlus4E;
  logic        ValidD, ValidE, RegWriteE, ResultSrcE0, MemWriteE;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] StallCnt, FlushCnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_regs dut (
    .clk(clk), .reset(reset), .PCNextF(PCNextF), .InstrF(InstrF),
    .PCPlus4F(PCPlus4F), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .RegWriteD(RegWriteD), .ResultSrcD0(ResultSrcD0),
    .MemWriteD(MemWriteD), .CntClr(CntClr), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .ResultSrcE0(ResultSrcE0), .MemWriteE(MemWriteE),
    .ValidE(ValidE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  // Model: a decode slot and an execute slot, each either empty
  // or holding an instruction record.
  typedef struct {
    bit          v;
    logic [31:0] instr, pc, pc4;
  } dslot_t;
  typedef struct {
    bit          v;
    logic [4:0]  rs1, rs2, rd;
    bit          rw, rs, mw;
    logic [31:0] pc, pc4;
  } eslot_t;

  logic [31:0] m_pc;
  dslot_t      m_d;
  eslot_t      m_e;
  int          m_sc, m_fc;

  function automatic dslot_t d_empty();
    dslot_t s;
    s.v = 0; s.instr = NOP; s.pc = 0; s.pc4 = 0;
    return s;
  endfunction

  function automatic eslot_t e_empty();
    eslot_t s;
    s.v = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
    s.rw = 0; s.rs = 0; s.mw = 0; s.pc = 0; s.pc4 = 0;
    return s;
  endfunction

  task automatic model_step();
    dslot_t nd;
    eslot_t ne;
    if (reset) begin
      m_pc = 32'h0; m_d = d_empty(); m_e = e_empty();
      m_sc = 0; m_fc = 0;
      return;
    end
    if (FlushE) ne = e_empty();
    else begin
      ne.v = m_d.v;
      ne.rs1 = Rs1D; ne.rs2 = Rs2D; ne.rd = RdD;
      // an invalid instruction carries no side effects
      ne.rw = m_d.v && RegWriteD;
      ne.rs = m_d.v && ResultSrcD0;
      ne.mw = m_d.v && MemWriteD;
      ne.pc = m_d.pc; ne.pc4 = m_d.pc4;
    end
    if (FlushD) nd = d_empty();
    else if (StallD) nd = m_d;
    else begin
      nd.v = 1; nd.instr = InstrF; nd.pc = m_pc; nd.pc4 = PCPlus4F;
    end
    if (CntClr) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (StallF) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
      if (FlushD) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    end
    if (!StallF) m_pc = PCNextF;
    m_d = nd;
    m_e = ne;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_all();
    check("PCF", PCF, m_pc);
    check("InstrD", InstrD, m_d.instr);
    check("PCD", PCD, m_d.pc);
    check("PCPlus4D", PCPlus4D, m_d.pc4);
    check("ValidD", 32'(ValidD), 32'(m_d.v));
    check("Rs1E", 32'(Rs1E), 32'(m_e.rs1));
    check("Rs2E", 32'(Rs2E), 32'(m_e.rs2));
    check("RdE", 32'(RdE), 32'(m_e.rd));
    check("RegWriteE", 32'(RegWriteE), 32'(m_e.rw));
    check("ResultSrcE0", 32'(ResultSrcE0), 32'(m_e.rs));
    check("MemWriteE", 32'(MemWriteE), 32'(m_e.mw));
    check("ValidE", 32'(ValidE), 32'(m_e.v));
    check("PCE", PCE, m_e.pc);
    check("PCPlus4E", PCPlus4E, m_e.pc4);
    check("StallCnt", 32'(StallCnt), 32'(m_sc));
    check("FlushCnt", 32'(FlushCnt), 32'(m_fc));
  endtask

  task automatic tick(input bit do_chk);
    @(posedge clk);
    model_step();
    #1;
    if (do_chk) check_all();
  endtask

  task automatic idle();
    reset = 0; StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
    CntClr = 0;
  endtask

  task automatic free_fetch();
    PCNextF = m_pc + 32'd4;
    PCPlus4F = m_pc + 32'd4;
  endtask

  initial begin
    idle();
    reset = 1;
    PCNextF = 0; InstrF = 32'h00500093; PCPlus4F = 0;
    Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
    RegWriteD = 1; ResultSrcD0 = 0; MemWriteD = 0;
    #2;
    tick(1);
    check("rst_InstrD", InstrD, NOP);
    check("rst_ValidE", 32'(ValidE), 32'd0);

    // free run
    idle(); free_fetch(); tick(1);
    check("run_PCF1", PCF, 32'd4);
    check("run_InstrD", InstrD, 32'h00500093);
    check("run_ValidD", 32'(ValidD), 32'd1);
    free_fetch(); tick(1);
    check("run_PCF2", PCF, 32'd8);
    check("run_ValidE", 32'(ValidE), 32'd1);

    // load-use stall at PCF=8
    free_fetch(); InstrF = 32'h00A00113;
    StallF = 1; StallD = 1; FlushE = 1; tick(1);
    check("stall_PCF", PCF, 32'd8);
    check("stall_InstrD", InstrD, 32'h00500093);
    check("stall_ValidE", 32'(ValidE), 32'd0);
    check("stall_Cnt", 32'(StallCnt), 32'd1);

    // taken branch
    idle(); free_fetch(); FlushD = 1; FlushE = 1; tick(1);
    check("br_InstrD", InstrD, NOP);
    check("br_RegWriteE", 32'(RegWriteE), 32'd0);
    check("br_FlushCnt", 32'(FlushCnt), 32'd1);

    // invalid slot into EX must stay side-effect free
    idle(); free_fetch(); FlushD = 1; tick(1);
    idle(); free_fetch(); tick(1);
    check("bub_ValidE", 32'(ValidE), 32'd0);
    check("bub_RegWriteE", 32'(RegWriteE), 32'd0);

    // flush beats stall
    free_fetch(); FlushD = 1; StallD = 1; tick(1);
    check("fs_InstrD", InstrD, NOP);
    check("fs_ValidD", 32'(ValidD), 32'd0);

    // reset during a stall at PCF=0x20
    idle(); PCNextF = 32'h20; tick(1);
    check("pre_PCF", PCF, 32'h20);
    StallF = 1; StallD = 1; FlushD = 1; CntClr = 0; reset = 1;
    tick(1);
    check("rs_PCF", PCF, 32'h0);
    check("rs_ValidD", 32'(ValidD), 32'd0);
    check("rs_FlushCnt", 32'(FlushCnt), 32'd0);
    idle(); free_fetch(); tick(1);
    check("rs_resume", PCF, 32'd4);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) < 2);
      StallF = ($urandom_range(0, 99) < 20);
      StallD = ($urandom_range(0, 99) < 20);
      FlushD = ($urandom_range(0, 99) < 15);
      FlushE = ($urandom_range(0, 99) < 15);
      CntClr = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 3) == 0) PCNextF = $urandom;
      else PCNextF = m_pc + 32'd4;
      InstrF = $urandom;
      PCPlus4F = $urandom;
      Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
      RegWriteD = 1'($urandom);
      ResultSrcD0 = 1'($urandom);
      MemWriteD = 1'($urandom);
      tick(1);
    end

    // counter saturation
    idle(); reset = 1; tick(1);
    idle(); StallF = 1;
    for (int i = 0; i < CMAX + 4; i++) tick(0);
    check_all();
    check("sat_StallCnt", 32'(StallCnt), 32'hFFFF);
    CntClr = 1; tick(1);
    check("clr_StallCnt", 32'(StallCnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
